// File: rtl/data_ram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_ram_resp                                                |
// | Description : Data-memory responder behind the MEM-stage load/store port.  |
// |               Latches one word request, services it from an internal       |
// |               word-addressed RAM after WAIT_CYCLES, then pulses ready_o    |
// |               for one cycle. stall_req_o holds the pipeline while busy.    |
// |               Optional feature macro: DRAM_ALIGN_CHK_EN (misaligned        |
// |               accesses flagged on err_o, store suppressed, load returns 0).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stall_req_o
);

  localparam int         c_DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WAIT     = 2'd1;
  localparam logic [1:0] c_RESP     = 2'd2;
  // Last WAIT count value before moving on to RESP (unused when WAIT_CYCLES=0).
  localparam logic [3:0] c_CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [3:0]        r_cnt;

  // Latched request
  logic              r_we;
  logic [ADDR_W-1:0] r_idx;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdata;
  logic              r_mis;

  // Response registers
  logic [31:0]       r_data;
  logic              r_err;

  logic [31:0]       r_mem [c_DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_in_mis;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [3:0]        w_acc_sel;
  logic [31:0]       w_acc_data;
  logic              w_acc_mis;
  logic              w_unused;

`ifdef DRAM_ALIGN_CHK_EN
  assign w_in_mis = (addr_i[1:0] != 2'b00);
`else
  assign w_in_mis = 1'b0;
`endif

  // Upper address bits alias away; low bits only matter with the align check.
  assign w_unused = &{1'b0, addr_i};

  assign w_accept     = (r_state == c_IDLE) && ce_i;
  assign w_enter_resp = (r_state != c_RESP) && (w_next == c_RESP);

  // Access operands: straight from the inputs when RESP is entered from IDLE
  // (WAIT_CYCLES=0, latch and access share the edge), else the latched copy.
  always_comb begin
    w_acc_we   = r_we;
    w_acc_idx  = r_idx;
    w_acc_sel  = r_sel;
    w_acc_data = r_wdata;
    w_acc_mis  = r_mis;
    if (r_state == c_IDLE) begin
      w_acc_we   = we_i;
      w_acc_idx  = addr_i[ADDR_W+1:2];
      w_acc_sel  = sel_i;
      w_acc_data = data_i;
      w_acc_mis  = w_in_mis;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (ce_i) begin
          w_next = (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_cnt == c_CNT_LAST) begin
          w_next = c_RESP;
        end
      end
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // State register, wait counter and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= 4'd0;
      r_wdata <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 4'd0;
        r_we    <= we_i;
        r_idx   <= addr_i[ADDR_W+1:2];
        r_sel   <= sel_i;
        r_wdata <= data_i;
        r_mis   <= w_in_mis;
      end else if (r_state == c_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Response registers load on the edge entering RESP and hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 32'd0;
      r_err  <= 1'b0;
    end else if (w_enter_resp) begin
      r_err  <= w_acc_mis;
      r_data <= (w_acc_we || w_acc_mis) ? 32'd0 : r_mem[w_acc_idx];
    end
  end

  // Byte-lane RAM write; rst gating drops a store aborted at its access edge
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_acc_we && !w_acc_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_sel[b]) begin
          r_mem[w_acc_idx][8*b +: 8] <= w_acc_data[8*b +: 8];
        end
      end
    end
  end

  // Output decode
  always_comb begin
    ready_o     = (r_state == c_RESP);
    err_o       = (r_state == c_RESP) && r_err;
    data_o      = r_data;
    stall_req_o = ((r_state == c_IDLE) && ce_i) || (r_state == c_WAIT);
  end

endmodule
`default_nettype wire
